// File: rtl/tlb_fa_store.sv
// Fully-associative VPN/ASID -> PPN translation store.
// Registered lookup response, fill with dedup/free/PLRU victim choice, ASID or global flush.
module tlb_fa_store #(
  parameter int ENTRIES = 8,
  parameter int VPN_W   = 27,
  parameter int PPN_W   = 44,
  parameter int ASID_W  = 16,
  localparam int IW     = $clog2(ENTRIES)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              lu_req_i,
  input  logic [VPN_W-1:0]  lu_vpn_i,
  input  logic [ASID_W-1:0] lu_asid_i,
  output logic              lu_valid_o,
  output logic              lu_hit_o,
  output logic [PPN_W-1:0]  lu_ppn_o,
  input  logic              fill_valid_i,
  output logic              fill_ready_o,
  input  logic [VPN_W-1:0]  fill_vpn_i,
  input  logic [ASID_W-1:0] fill_asid_i,
  input  logic [PPN_W-1:0]  fill_ppn_i,
  input  logic              flush_i,
  input  logic              flush_asid_valid_i,
  input  logic [ASID_W-1:0] flush_asid_i,
  output logic              plru_hit_o,
  output logic [IW-1:0]     plru_idx_o,
  input  logic [IW-1:0]     plru_repl_idx_i
);

  logic [ENTRIES-1:0] valid_q;
  logic [VPN_W-1:0]   vpn_q  [ENTRIES];
  logic [ASID_W-1:0]  asid_q [ENTRIES];
  logic [PPN_W-1:0]   ppn_q  [ENTRIES];

  logic [ENTRIES-1:0] lu_match;
  logic [ENTRIES-1:0] fill_match;
  logic               lu_any;
  logic [IW-1:0]      lu_idx;
  logic               dup_any;
  logic [IW-1:0]      dup_idx;
  logic               free_any;
  logic [IW-1:0]      free_idx;
  logic [IW-1:0]      victim;
  logic               lu_hit_c;
  logic               fill_fire;

  logic               lu_valid_q;
  logic               lu_hit_q;
  logic [PPN_W-1:0]   lu_ppn_q;

  always_comb begin
    for (int i = 0; i < ENTRIES; i++) begin
      lu_match[i] = valid_q[i]
                  & (vpn_q[i] == lu_vpn_i)
                  & (asid_q[i] == lu_asid_i);
      fill_match[i] = valid_q[i]
                    & (vpn_q[i] == fill_vpn_i)
                    & (asid_q[i] == fill_asid_i);
    end
  end

  // Scan downward so the lowest matching index is the one left standing.
  always_comb begin
    lu_any   = 1'b0;
    lu_idx   = '0;
    dup_any  = 1'b0;
    dup_idx  = '0;
    free_any = 1'b0;
    free_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (lu_match[i]) begin
        lu_any = 1'b1;
        lu_idx = IW'(i);
      end
      if (fill_match[i]) begin
        dup_any = 1'b1;
        dup_idx = IW'(i);
      end
      if (!valid_q[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    end
  end

  always_comb begin
    victim = plru_repl_idx_i;
    if (dup_any) begin
      victim = dup_idx;
    end else if (free_any) begin
      victim = free_idx;
    end
  end

  assign fill_ready_o = ~flush_i;
  assign fill_fire    = fill_valid_i & ~flush_i;
  assign lu_hit_c     = lu_req_i & lu_any & ~flush_i;

  // A lookup hit owns the PLRU port; a concurrent fill goes untouched.
  always_comb begin
    plru_hit_o = 1'b0;
    plru_idx_o = '0;
    if (lu_hit_c) begin
      plru_hit_o = 1'b1;
      plru_idx_o = lu_idx;
    end else if (fill_fire) begin
      plru_hit_o = 1'b1;
      plru_idx_o = victim;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      lu_valid_q <= 1'b0;
      lu_hit_q   <= 1'b0;
      lu_ppn_q   <= '0;
    end else begin
      lu_valid_q <= lu_req_i;
      lu_hit_q   <= lu_hit_c;
      lu_ppn_q   <= lu_hit_c ? ppn_q[lu_idx] : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < ENTRIES; i++) begin
        if (!flush_asid_valid_i || (asid_q[i] == flush_asid_i)) begin
          valid_q[i] <= 1'b0;
        end
      end
    end else if (fill_fire) begin
      valid_q[victim] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (fill_fire) begin
      vpn_q[victim]  <= fill_vpn_i;
      asid_q[victim] <= fill_asid_i;
      ppn_q[victim]  <= fill_ppn_i;
    end
  end

  assign lu_valid_o = lu_valid_q;
  assign lu_hit_o   = lu_hit_q;
  assign lu_ppn_o   = lu_ppn_q;

endmodule

// File: tb/tb_tlb_fa_store.sv
// Directed bench for tlb_fa_store.
// Inputs change on negedge; combinational PLRU port sampled before posedge.
module tb_tlb_fa_store;
  localparam int VPN_W  = 27;
  localparam int PPN_W  = 44;
  localparam int ASID_W = 16;
  localparam int IW     = 3;

  logic              clk = 1'b0;
  logic              rstn;
  logic              lu_req;
  logic [VPN_W-1:0]  lu_vpn;
  logic [ASID_W-1:0] lu_asid;
  logic              lu_valid;
  logic              lu_hit;
  logic [PPN_W-1:0]  lu_ppn;
  logic              fill_valid;
  logic              fill_ready;
  logic [VPN_W-1:0]  fill_vpn;
  logic [ASID_W-1:0] fill_asid;
  logic [PPN_W-1:0]  fill_ppn;
  logic              flush;
  logic              flush_asid_valid;
  logic [ASID_W-1:0] flush_asid;
  logic              plru_hit;
  logic [IW-1:0]     plru_idx;
  logic [IW-1:0]     plru_repl;

  int n_chk  = 0;
  int n_pass = 0;

  tlb_fa_store #(
    .ENTRIES(8), .VPN_W(VPN_W), .PPN_W(PPN_W), .ASID_W(ASID_W)
  ) dut (
    .clk_i              (clk),
    .rstn_i             (rstn),
    .lu_req_i           (lu_req),
    .lu_vpn_i           (lu_vpn),
    .lu_asid_i          (lu_asid),
    .lu_valid_o         (lu_valid),
    .lu_hit_o           (lu_hit),
    .lu_ppn_o           (lu_ppn),
    .fill_valid_i       (fill_valid),
    .fill_ready_o       (fill_ready),
    .fill_vpn_i         (fill_vpn),
    .fill_asid_i        (fill_asid),
    .fill_ppn_i         (fill_ppn),
    .flush_i            (flush),
    .flush_asid_valid_i (flush_asid_valid),
    .flush_asid_i       (flush_asid),
    .plru_hit_o         (plru_hit),
    .plru_idx_o         (plru_idx),
    .plru_repl_idx_i    (plru_repl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic fill(input logic [VPN_W-1:0]  v,
                      input logic [ASID_W-1:0] a,
                      input logic [PPN_W-1:0]  p,
                      input int                idx);
    @(negedge clk);
    fill_valid = 1'b1;
    fill_vpn   = v;
    fill_asid  = a;
    fill_ppn   = p;
    #1;
    check($sformatf("fill_rdy v%0h", v), 64'(fill_ready), 64'd1);
    check($sformatf("fill_touch v%0h", v), 64'(plru_hit), 64'd1);
    check($sformatf("fill_idx v%0h", v), 64'(plru_idx), 64'(idx));
    @(posedge clk);
    #1 fill_valid = 1'b0;
  endtask

  task automatic lookup(input logic [VPN_W-1:0]  v,
                        input logic [ASID_W-1:0] a,
                        input logic              h,
                        input logic [PPN_W-1:0]  p,
                        input int                idx);
    @(negedge clk);
    lu_req  = 1'b1;
    lu_vpn  = v;
    lu_asid = a;
    #1;
    check($sformatf("lu_touch v%0h", v), 64'(plru_hit), 64'(h));
    check($sformatf("lu_tidx v%0h", v), 64'(plru_idx), 64'(idx));
    @(posedge clk);
    #1 lu_req = 1'b0;
    check($sformatf("lu_valid v%0h", v), 64'(lu_valid), 64'd1);
    check($sformatf("lu_hit v%0h", v), 64'(lu_hit), 64'(h));
    check($sformatf("lu_ppn v%0h", v), 64'(lu_ppn), 64'(p));
  endtask

  initial begin
    rstn = 1'b0;
    lu_req = 1'b0; lu_vpn = '0; lu_asid = '0;
    fill_valid = 1'b0; fill_vpn = '0; fill_asid = '0; fill_ppn = '0;
    flush = 1'b0; flush_asid_valid = 1'b0; flush_asid = '0;
    plru_repl = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst lu_valid", 64'(lu_valid), 64'd0);
    check("rst lu_hit", 64'(lu_hit), 64'd0);
    check("rst lu_ppn", 64'(lu_ppn), 64'd0);
    check("rst fill_rdy", 64'(fill_ready), 64'd1);
    check("rst plru_hit", 64'(plru_hit), 64'd0);
    check("rst plru_idx", 64'(plru_idx), 64'd0);
    @(negedge clk) rstn = 1'b1;

    // first fill and lookup
    lookup(27'h10, 16'd1, 1'b0, 44'h0, 0);
    fill(27'h10, 16'd1, 44'hABC, 0);
    lookup(27'h10, 16'd1, 1'b1, 44'hABC, 0);
    @(negedge clk);
    @(posedge clk);
    #1 check("lu_valid falls", 64'(lu_valid), 64'd0);

    // fill to full, then PLRU victim
    for (int i = 1; i < 8; i++) fill(27'h10 + 27'(i), 16'd1, 44'h100 + 44'(i), i);
    lookup(27'h17, 16'd1, 1'b1, 44'h107, 7);
    lookup(27'h10, 16'd2, 1'b0, 44'h0, 0);
    plru_repl = 3'd5;
    fill(27'h20, 16'd1, 44'h555, 5);
    lookup(27'h15, 16'd1, 1'b0, 44'h0, 0);
    lookup(27'h20, 16'd1, 1'b1, 44'h555, 5);

    // refill of resident mapping overwrites in place
    fill(27'h10, 16'd1, 44'h123, 0);
    lookup(27'h10, 16'd1, 1'b1, 44'h123, 0);

    // lookup hit at 3 with concurrent fill -> lookup owns PLRU
    plru_repl = 3'd6;
    @(negedge clk);
    lu_req = 1'b1; lu_vpn = 27'h13; lu_asid = 16'd1;
    fill_valid = 1'b1; fill_vpn = 27'h30; fill_asid = 16'd2; fill_ppn = 44'h777;
    #1;
    check("sim touch", 64'(plru_hit), 64'd1);
    check("sim idx", 64'(plru_idx), 64'd3);
    @(posedge clk);
    #1 lu_req = 1'b0; fill_valid = 1'b0;
    check("sim lu_hit", 64'(lu_hit), 64'd1);
    check("sim lu_ppn", 64'(lu_ppn), 64'h103);
    lookup(27'h30, 16'd2, 1'b1, 44'h777, 6);

    // same-cycle fill and lookup of same VPN: miss now, hit next
    plru_repl = 3'd7;
    @(negedge clk);
    lu_req = 1'b1; lu_vpn = 27'h40; lu_asid = 16'd2;
    fill_valid = 1'b1; fill_vpn = 27'h40; fill_asid = 16'd2; fill_ppn = 44'h888;
    #1;
    check("same touch", 64'(plru_hit), 64'd1);
    check("same idx", 64'(plru_idx), 64'd7);
    @(posedge clk);
    #1 lu_req = 1'b0; fill_valid = 1'b0;
    check("same lu_hit", 64'(lu_hit), 64'd0);
    check("same lu_ppn", 64'(lu_ppn), 64'd0);
    lookup(27'h40, 16'd2, 1'b1, 44'h888, 7);

    // ASID-1 flush with a held fill and a blocked lookup
    @(negedge clk);
    flush = 1'b1; flush_asid_valid = 1'b1; flush_asid = 16'd1;
    fill_valid = 1'b1; fill_vpn = 27'h50; fill_asid = 16'd3; fill_ppn = 44'h999;
    lu_req = 1'b1; lu_vpn = 27'h30; lu_asid = 16'd2;
    #1;
    check("flush fill_rdy", 64'(fill_ready), 64'd0);
    check("flush touch", 64'(plru_hit), 64'd0);
    check("flush idx", 64'(plru_idx), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0; lu_req = 1'b0;
    check("flush lu_hit", 64'(lu_hit), 64'd0);
    check("flush lu_valid", 64'(lu_valid), 64'd1);
    #1;
    check("held fill_rdy", 64'(fill_ready), 64'd1);
    check("held touch", 64'(plru_hit), 64'd1);
    check("held idx", 64'(plru_idx), 64'd0);
    @(posedge clk);
    #1 fill_valid = 1'b0;
    lookup(27'h12, 16'd1, 1'b0, 44'h0, 0);
    lookup(27'h20, 16'd1, 1'b0, 44'h0, 0);
    lookup(27'h30, 16'd2, 1'b1, 44'h777, 6);
    lookup(27'h40, 16'd2, 1'b1, 44'h888, 7);
    lookup(27'h50, 16'd3, 1'b1, 44'h999, 0);

    // global flush
    @(negedge clk);
    flush = 1'b1; flush_asid_valid = 1'b0;
    @(posedge clk);
    #1 flush = 1'b0;
    lookup(27'h30, 16'd2, 1'b0, 44'h0, 0);
    lookup(27'h50, 16'd3, 1'b0, 44'h0, 0);

    // reset with a response in flight
    fill(27'h60, 16'd4, 44'h666, 0);
    @(negedge clk);
    lu_req = 1'b1; lu_vpn = 27'h60; lu_asid = 16'd4;
    @(posedge clk);
    #1 lu_req = 1'b0;
    check("pre-rst lu_hit", 64'(lu_hit), 64'd1);
    rstn = 1'b0;
    #1;
    check("mid-rst lu_valid", 64'(lu_valid), 64'd0);
    check("mid-rst lu_hit", 64'(lu_hit), 64'd0);
    check("mid-rst lu_ppn", 64'(lu_ppn), 64'd0);
    @(negedge clk) rstn = 1'b1;
    lookup(27'h60, 16'd4, 1'b0, 44'h0, 0);
    lookup(27'h40, 16'd2, 1'b0, 44'h0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
